// File: rtl/fixed_to_float_seq_if.sv
// Handshake and data bundle for the fixed-to-float converter.
// The master drives the operand and start pulse; the slave returns busy, done and result.
interface fixed_to_float_seq_if;
  logic        start;
  logic [31:0] fixed;
  logic [4:0]  fixpointpos;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, fixed, fixpointpos,
    input  busy, done, result
  );

  modport slave (
    input  start, fixed, fixpointpos,
    output busy, done, result
  );
endinterface

// File: rtl/fixed_to_float_seq.sv
// Iterative 32-bit two's-complement fixed-point to IEEE-754 single converter.
// Normalises one bit per cycle and truncates the mantissa (round toward zero).
module fixed_to_float_seq (
  input  logic                  clk,
  input  logic                  rst,
  fixed_to_float_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  fpp_q, fpp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [7:0]  exp_w;

  // Biased exponent: 127 + 31 - shifts - fractional bits, always within 96..158.
  assign exp_w = 8'd158 - {3'b000, cnt_q} - {3'b000, fpp_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      fpp_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      fpp_q    <= fpp_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    fpp_d    = fpp_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.fixed[31];
          // Negating 0x80000000 wraps back to 0x80000000, the correct magnitude.
          mag_d   = bus.fixed[31] ? (~bus.fixed + 32'd1) : bus.fixed;
          fpp_d   = bus.fixpointpos;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mag_q == 32'd0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else if (mag_q[31]) begin
          state_d = PACK;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end

      PACK: begin
        result_d = zero_q ? 32'h0000_0000 : {sign_q, exp_w, mag_q[30:8]};
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
